// File: rtl/cms_pkg.sv
// rtl/cms_pkg.sv - shared types and register map for the multi-range trace gate
package cms_pkg;

    localparam int CMS_ADDR_W = 64;

    localparam logic [7:0] CTRL_START_EN       = 8'd0;
    localparam logic [7:0] CTRL_END_EN         = 8'd1;
    localparam logic [7:0] CTRL_START_ADDR     = 8'd2;
    localparam logic [7:0] CTRL_END_ADDR       = 8'd3;
    localparam logic [7:0] CTRL_REARM          = 8'd4;
    localparam logic [7:0] CTRL_TLAST_INTERVAL = 8'd5;
    localparam logic [7:0] CTRL_RETRIGGER_EN   = 8'd6;
    localparam logic [7:0] CTRL_CLEAR_DROPS    = 8'd7;
    localparam logic [7:0] CTRL_RANGE_BASE     = 8'd16;

    localparam int RANGE_LOWER  = 0;
    localparam int RANGE_UPPER  = 1;
    localparam int RANGE_ENABLE = 2;
    localparam int RANGE_MODE   = 3;

    localparam logic [31:0] WFI_INSTRUCTION = 32'h0000_0001;

    typedef enum logic [1:0] {
        TRACE_ARMED   = 2'd0,
        TRACE_TRACING = 2'd1,
        TRACE_ENDED   = 2'd2,
        TRACE_HALTED  = 2'd3
    } trace_state_e;

    typedef enum logic {
        RANGE_INCLUDE = 1'b0,
        RANGE_EXCLUDE = 1'b1
    } range_mode_e;

    typedef struct packed {
        logic [CMS_ADDR_W-1:0] lower;
        logic [CMS_ADDR_W-1:0] upper;
        logic                  enable;
        range_mode_e           mode;
    } range_t;

    // Each range owns a block of four consecutive control addresses.
    function automatic logic [7:0] range_reg_addr(input int idx, input int field);
        return 8'(int'(CTRL_RANGE_BASE) + 4 * idx + field);
    endfunction

endpackage

// File: rtl/cms_stream_fifo.sv
// rtl/cms_stream_fifo.sv - synchronous FIFO with stream read side and occupancy level
module cms_stream_fifo #(
    parameter int DATA_W = 96,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [LW-1:0]     level
);

    logic [DATA_W:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level_q;
    logic            full;
    logic            push;
    logic            pop;

    assign full     = (level_q == LW'(DEPTH));
    assign m_tvalid = (level_q != '0);
    assign pop      = m_tvalid && m_tready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign s_tready = !full || pop;
    assign push     = s_tvalid && s_tready;
    assign level    = level_q;

    assign {m_tlast, m_tdata} = m_tvalid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_tlast, s_tdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/cms_multi_range_trace_gate.sv
// rtl/cms_multi_range_trace_gate.sv - range and trigger filtered trace gate with stream output
module cms_multi_range_trace_gate
    import cms_pkg::*;
#(
    parameter int XLEN                                = 64,
    parameter int NUM_RANGES                          = 4,
    parameter int FIFO_DEPTH                          = 16,
    parameter int CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   instr,
    input  logic [XLEN-1:0]               pc,
    input  logic                          pc_valid,
    output logic                          M_AXIS_tvalid,
    input  logic                          M_AXIS_tready,
    output logic [XLEN+31:0]              M_AXIS_tdata,
    output logic                          M_AXIS_tlast,
    input  logic [7:0]                    ctrl_addr,
    input  logic [63:0]                   ctrl_wdata,
    input  logic                          ctrl_write_enable,
    output logic [1:0]                    trace_state,
    output logic [31:0]                   dropped_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    logic                  ctrl_we_q;
    logic                  ctrl_fire;
    logic                  rearm;
    logic                  clear_drops;

    logic                  start_en;
    logic                  end_en;
    logic                  retrigger_en;
    logic [XLEN-1:0]       start_addr;
    logic [XLEN-1:0]       end_addr;
    logic [31:0]           tlast_interval;
    range_t                ranges [NUM_RANGES];

    trace_state_e          state_q;
    trace_state_e          state_d;
    logic                  gate_open;
    logic                  is_wfi;
    logic                  start_hit;
    logic                  end_hit;

    logic [CMS_ADDR_W-1:0] pc_ext;
    logic [NUM_RANGES-1:0] incl_en;
    logic [NUM_RANGES-1:0] incl_hit;
    logic [NUM_RANGES-1:0] excl_hit;
    logic                  in_range;

    logic                  admit;
    logic                  fifo_ready;
    logic                  push_ok;
    logic                  drop;
    logic                  last_beat;
    logic [31:0]           beat_count;

    // Edge mode fires once per rising edge; level mode fires every high cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_we_q <= 1'b0;
        end else begin
            ctrl_we_q <= ctrl_write_enable;
        end
    end

    assign ctrl_fire   = ctrl_write_enable &&
                         ((CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED == 0) || !ctrl_we_q);
    assign rearm       = ctrl_fire && (ctrl_addr == CTRL_REARM);
    assign clear_drops = ctrl_fire && (ctrl_addr == CTRL_CLEAR_DROPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_en       <= 1'b0;
            end_en         <= 1'b0;
            retrigger_en   <= 1'b0;
            start_addr     <= '0;
            end_addr       <= '1;
            tlast_interval <= '0;
            for (int i = 0; i < NUM_RANGES; i++) begin
                ranges[i].lower  <= '0;
                ranges[i].upper  <= '1;
                ranges[i].enable <= 1'b0;
                ranges[i].mode   <= RANGE_INCLUDE;
            end
        end else if (ctrl_fire) begin
            case (ctrl_addr)
                CTRL_START_EN:       start_en       <= ctrl_wdata[0];
                CTRL_END_EN:         end_en         <= ctrl_wdata[0];
                CTRL_START_ADDR:     start_addr     <= XLEN'(ctrl_wdata);
                CTRL_END_ADDR:       end_addr       <= XLEN'(ctrl_wdata);
                CTRL_TLAST_INTERVAL: tlast_interval <= ctrl_wdata[31:0];
                CTRL_RETRIGGER_EN:   retrigger_en   <= ctrl_wdata[0];
                default: ;
            endcase
            for (int i = 0; i < NUM_RANGES; i++) begin
                if (ctrl_addr == range_reg_addr(i, RANGE_LOWER)) begin
                    ranges[i].lower <= ctrl_wdata;
                end
                if (ctrl_addr == range_reg_addr(i, RANGE_UPPER)) begin
                    ranges[i].upper <= ctrl_wdata;
                end
                if (ctrl_addr == range_reg_addr(i, RANGE_ENABLE)) begin
                    ranges[i].enable <= ctrl_wdata[0];
                end
                if (ctrl_addr == range_reg_addr(i, RANGE_MODE)) begin
                    ranges[i].mode <= range_mode_e'(ctrl_wdata[0]);
                end
            end
        end
    end

    assign pc_ext = CMS_ADDR_W'(pc);

    for (genvar g = 0; g < NUM_RANGES; g++) begin : g_range
        logic hit;
        assign hit         = (pc_ext >= ranges[g].lower) && (pc_ext <= ranges[g].upper);
        assign incl_en[g]  = ranges[g].enable && (ranges[g].mode == RANGE_INCLUDE);
        assign incl_hit[g] = incl_en[g] && hit;
        assign excl_hit[g] = ranges[g].enable && (ranges[g].mode == RANGE_EXCLUDE) && hit;
    end

    // With no include range enabled the include side passes everything.
    assign in_range  = (!(|incl_en) || (|incl_hit)) && !(|excl_hit);

    assign is_wfi    = (instr == WFI_INSTRUCTION);
    assign start_hit = (pc == start_addr);
    assign end_hit   = end_en && (pc == end_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TRACE_ARMED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rearm) begin
            state_d = TRACE_ARMED;
        end else begin
            case (state_q)
                TRACE_ARMED: begin
                    if (pc_valid && gate_open) begin
                        if (is_wfi) begin
                            state_d = TRACE_HALTED;
                        end else if (start_en && start_hit) begin
                            state_d = TRACE_TRACING;
                        end
                    end
                end
                TRACE_TRACING: begin
                    if (pc_valid) begin
                        if (is_wfi) begin
                            state_d = TRACE_HALTED;
                        end else if (end_hit) begin
                            state_d = TRACE_ENDED;
                        end
                    end
                end
                TRACE_ENDED: begin
                    if (retrigger_en) begin
                        state_d = TRACE_ARMED;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        gate_open = 1'b0;
        case (state_q)
            TRACE_ARMED:   gate_open = !start_en || start_hit;
            TRACE_TRACING: gate_open = 1'b1;
            default:       gate_open = 1'b0;
        endcase
    end

    assign trace_state = state_q;

    assign admit     = pc_valid && gate_open && in_range;
    assign push_ok   = admit && fifo_ready;
    assign drop      = admit && !fifo_ready;
    assign last_beat = is_wfi ||
                       ((tlast_interval != 32'd0) && (beat_count == tlast_interval - 32'd1));

    // Only packets that actually enter the FIFO advance packetisation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count <= '0;
        end else if (rearm) begin
            beat_count <= '0;
        end else if (push_ok) begin
            beat_count <= last_beat ? 32'd0 : beat_count + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropped_count <= '0;
        end else if (clear_drops) begin
            dropped_count <= '0;
        end else if (drop && (dropped_count != 32'hFFFF_FFFF)) begin
            dropped_count <= dropped_count + 32'd1;
        end
    end

    cms_stream_fifo #(
        .DATA_W (XLEN + 32),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  ({pc, instr}),
        .s_tlast  (last_beat),
        .s_tvalid (admit),
        .s_tready (fifo_ready),
        .m_tdata  (M_AXIS_tdata),
        .m_tlast  (M_AXIS_tlast),
        .m_tvalid (M_AXIS_tvalid),
        .m_tready (M_AXIS_tready),
        .level    (fifo_level)
    );

endmodule

// File: tb/tb_cms_multi_range_trace_gate.sv
// tb/tb_cms_multi_range_trace_gate.sv - directed self-checking bench for the trace gate
module tb_cms_multi_range_trace_gate;

    localparam int XLEN = 64;
    localparam int FD   = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] WFI = 32'h0000_0001;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       instr = '0;
    logic [XLEN-1:0]   pc = '0;
    logic              pc_valid = 1'b0;
    logic              tvalid;
    logic              tready = 1'b0;
    logic [XLEN+31:0]  tdata;
    logic              tlast;
    logic [7:0]        ctrl_addr = '0;
    logic [63:0]       ctrl_wdata = '0;
    logic              ctrl_we = 1'b0;
    logic [1:0]        trace_state;
    logic [31:0]       dropped_count;
    logic [4:0]        fifo_level;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [XLEN+32:0] beats [$];

    int exp_once [8] = '{0, 0, 1, 1, 1, 2, 2, 2};
    int exp_rtrg [8] = '{0, 0, 1, 1, 1, 2, 0, 0};
    logic exp_last [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    cms_multi_range_trace_gate dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .instr             (instr),
        .pc                (pc),
        .pc_valid          (pc_valid),
        .M_AXIS_tvalid     (tvalid),
        .M_AXIS_tready     (tready),
        .M_AXIS_tdata      (tdata),
        .M_AXIS_tlast      (tlast),
        .ctrl_addr         (ctrl_addr),
        .ctrl_wdata        (ctrl_wdata),
        .ctrl_write_enable (ctrl_we),
        .trace_state       (trace_state),
        .dropped_count     (dropped_count),
        .fifo_level        (fifo_level)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && tvalid && tready) beats.push_back({tlast, tdata});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        pc_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic ctrl_write(input logic [7:0] a, input logic [63:0] d);
        ctrl_addr = a; ctrl_wdata = d; ctrl_we = 1'b1;
        step();
        ctrl_we = 1'b0;
        step();
    endtask

    task automatic send(input logic [XLEN-1:0] p, input logic [31:0] i);
        pc = p; instr = i; pc_valid = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        n_cmp++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", tvalid); end
        n_cmp++; if (tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", tlast); end
        n_cmp++; if (tdata !== '0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", tdata); end
        n_cmp++; if (trace_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", trace_state); end
        n_cmp++; if (dropped_count !== 32'd0) begin n_fail++; $display("FAIL reset_dropped: got %0d want 0", dropped_count); end
        n_cmp++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    endtask

    task automatic test_start_end(input logic rtrg, input int loops);
        logic [XLEN-1:0] p;
        int nb;
        ctrl_write(8'd4, 64'd0);
        ctrl_write(8'd0, 64'd1);
        ctrl_write(8'd2, 64'h100);
        ctrl_write(8'd1, 64'd1);
        ctrl_write(8'd3, 64'h10C);
        ctrl_write(8'd6, {63'd0, rtrg});
        tready = 1'b1;
        beats.delete();
        for (int l = 0; l < loops; l++) begin
            for (int k = 0; k < 8; k++) begin
                send(64'hF8 + 64'(4 * k), NOP);
                n_cmp++;
                if (int'(trace_state) != (rtrg ? exp_rtrg[k] : exp_once[k])) begin
                    n_fail++;
                    $display("FAIL fsm_state[%0d]: got %0d want %0d", k, trace_state,
                             rtrg ? exp_rtrg[k] : exp_once[k]);
                end
            end
        end
        idle(4);
        nb = 4 * loops;
        n_cmp++;
        if (beats.size() != nb) begin
            n_fail++;
            $display("FAIL start_end_count: got %0d want %0d", beats.size(), nb);
        end else begin
            for (int b = 0; b < nb; b++) begin
                p = beats[b][XLEN+31:32];
                n_cmp++;
                if (p !== 64'h100 + 64'(4 * (b % 4)) || beats[b][31:0] !== NOP || beats[b][XLEN+32] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL start_end_beat[%0d]: got pc %h want %h", b, p, 64'h100 + 64'(4 * (b % 4)));
                end
            end
        end
    endtask

    task automatic test_ranges();
        logic [XLEN-1:0] exp_pc [$];
        logic [XLEN-1:0] p;
        ctrl_write(8'd0, 64'd0);
        ctrl_write(8'd1, 64'd0);
        ctrl_write(8'd6, 64'd0);
        ctrl_write(8'd4, 64'd0);
        ctrl_write(8'd16, 64'h200);
        ctrl_write(8'd17, 64'h2FF);
        ctrl_write(8'd18, 64'd1);
        ctrl_write(8'd19, 64'd0);
        ctrl_write(8'd20, 64'h240);
        ctrl_write(8'd21, 64'h24F);
        ctrl_write(8'd22, 64'd1);
        ctrl_write(8'd23, 64'd1);
        tready = 1'b1;
        beats.delete();
        for (int k = 0; k < 66; k++) begin
            p = 64'h1FC + 64'(4 * k);
            if (p >= 64'h200 && p <= 64'h2FF && !(p >= 64'h240 && p <= 64'h24F)) exp_pc.push_back(p);
            send(p, NOP);
        end
        idle(4);
        n_cmp++;
        if (beats.size() != 60) begin
            n_fail++;
            $display("FAIL range_count: got %0d want 60", beats.size());
        end else begin
            n_cmp++;
            if (beats[0][XLEN+31:32] !== 64'h200) begin n_fail++; $display("FAIL range_first: got %h want 200", beats[0][XLEN+31:32]); end
            n_cmp++;
            if (beats[59][XLEN+31:32] !== 64'h2FC) begin n_fail++; $display("FAIL range_last: got %h want 2fc", beats[59][XLEN+31:32]); end
            for (int b = 0; b < 60; b++) begin
                n_cmp++;
                if (beats[b][XLEN+31:32] !== exp_pc[b]) begin
                    n_fail++;
                    $display("FAIL range_beat[%0d]: got %h want %h", b, beats[b][XLEN+31:32], exp_pc[b]);
                end
            end
        end
        ctrl_write(8'd18, 64'd0);
        ctrl_write(8'd22, 64'd0);
    endtask

    task automatic test_overflow();
        ctrl_write(8'd7, 64'd0);
        tready = 1'b0;
        beats.delete();
        for (int k = 0; k < 20; k++) send(64'h1000 + 64'(4 * k), NOP);
        idle(1);
        n_cmp++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL ovf_level: got %0d want 16", fifo_level); end
        n_cmp++; if (dropped_count !== 32'd4) begin n_fail++; $display("FAIL ovf_dropped: got %0d want 4", dropped_count); end
        n_cmp++; if (tvalid !== 1'b1 || tdata[XLEN+31:32] !== 64'h1000) begin n_fail++; $display("FAIL ovf_head: got %h want 1000", tdata[XLEN+31:32]); end
        idle(3);
        n_cmp++; if (tdata[XLEN+31:32] !== 64'h1000) begin n_fail++; $display("FAIL ovf_stall_stable: got %h want 1000", tdata[XLEN+31:32]); end
        tready = 1'b1;
        idle(20);
        n_cmp++;
        if (beats.size() != 16) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d want 16", beats.size());
        end else begin
            for (int b = 0; b < 16; b++) begin
                n_cmp++;
                if (beats[b][XLEN+31:32] !== 64'h1000 + 64'(4 * b)) begin
                    n_fail++;
                    $display("FAIL ovf_beat[%0d]: got %h want %h", b, beats[b][XLEN+31:32], 64'h1000 + 64'(4 * b));
                end
            end
        end
        n_cmp++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL ovf_drain_level: got %0d want 0", fifo_level); end
        ctrl_write(8'd7, 64'd0);
        n_cmp++; if (dropped_count !== 32'd0) begin n_fail++; $display("FAIL drop_clear: got %0d want 0", dropped_count); end
    endtask

    task automatic test_tlast_wfi();
        ctrl_write(8'd4, 64'd0);
        ctrl_write(8'd5, 64'd3);
        tready = 1'b1;
        beats.delete();
        for (int k = 0; k < 7; k++) send(64'h2000 + 64'(4 * k), NOP);
        send(64'h201C, WFI);
        pc_valid = 1'b0;
        n_cmp++; if (trace_state !== 2'd3) begin n_fail++; $display("FAIL wfi_state: got %0d want 3", trace_state); end
        idle(2);
        for (int k = 0; k < 3; k++) send(64'h3000 + 64'(4 * k), NOP);
        idle(3);
        n_cmp++; if (trace_state !== 2'd3) begin n_fail++; $display("FAIL halted_hold: got %0d want 3", trace_state); end
        n_cmp++;
        if (beats.size() != 8) begin
            n_fail++;
            $display("FAIL tlast_count: got %0d want 8", beats.size());
        end else begin
            for (int b = 0; b < 8; b++) begin
                n_cmp++;
                if (beats[b][XLEN+32] !== exp_last[b]) begin
                    n_fail++;
                    $display("FAIL tlast_beat[%0d]: got %b want %b", b, beats[b][XLEN+32], exp_last[b]);
                end
            end
            n_cmp++; if (beats[7][31:0] !== WFI) begin n_fail++; $display("FAIL wfi_instr: got %h want 1", beats[7][31:0]); end
        end
        ctrl_write(8'd4, 64'd0);
        n_cmp++; if (trace_state !== 2'd0) begin n_fail++; $display("FAIL rearm_state: got %0d want 0", trace_state); end
        send(64'h4000, NOP);
        idle(3);
        n_cmp++;
        if (beats.size() != 9 || beats[beats.size()-1][XLEN+31:32] !== 64'h4000 || beats[beats.size()-1][XLEN+32] !== 1'b0) begin
            n_fail++;
            $display("FAIL rearm_beat: got count %0d want 9 with pc 4000 tlast 0", beats.size());
        end
    endtask

    task automatic test_async_reset();
        ctrl_write(8'd5, 64'd0);
        tready = 1'b0;
        for (int k = 0; k < 18; k++) send(64'h5000 + 64'(4 * k), NOP);
        idle(1);
        ctrl_write(8'd0, 64'd1);
        ctrl_write(8'd2, 64'h999);
        ctrl_write(8'd5, 64'd1);
        tready = 1'b1;
        idle(12);
        tready = 1'b0;
        send(64'h999, NOP);
        pc_valid = 1'b0;
        n_cmp++; if (fifo_level !== 5'd5) begin n_fail++; $display("FAIL pre_reset_level: got %0d want 5", fifo_level); end
        n_cmp++; if (dropped_count !== 32'd2) begin n_fail++; $display("FAIL pre_reset_dropped: got %0d want 2", dropped_count); end
        n_cmp++; if (trace_state !== 2'd1) begin n_fail++; $display("FAIL pre_reset_state: got %0d want 1", trace_state); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL async_tvalid: got %b want 0", tvalid); end
        n_cmp++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL async_level: got %0d want 0", fifo_level); end
        n_cmp++; if (dropped_count !== 32'd0) begin n_fail++; $display("FAIL async_dropped: got %0d want 0", dropped_count); end
        n_cmp++; if (trace_state !== 2'd0) begin n_fail++; $display("FAIL async_state: got %0d want 0", trace_state); end
        n_cmp++; if (tdata !== '0) begin n_fail++; $display("FAIL async_tdata: got %h want 0", tdata); end
        step();
        rst_n = 1'b1;
        step();
        beats.delete();
        tready = 1'b1;
        send(64'h6000, NOP);
        send(64'h6004, NOP);
        idle(3);
        n_cmp++;
        if (beats.size() != 2 || beats[0][XLEN+31:32] !== 64'h6000 || beats[0][XLEN+32] !== 1'b0 ||
            beats[1][XLEN+32] !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_defaults: got count %0d want 2 beats from 6000 without tlast", beats.size());
        end
    endtask

    initial begin
        test_reset();
        test_start_end(1'b0, 1);
        test_start_end(1'b1, 2);
        test_ranges();
        test_overflow();
        test_tlast_wfi();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cms_multi_range_trace_gate.md
Name: cms_multi_range_trace_gate

Overview:
- Next-generation trace gate for the continuous monitoring system.
- Filters the executed {pc, instr} stream through N programmable address ranges (include/exclude) and a start/end/WFI trigger state machine with optional re-arm.
- Buffers admitted packets in an internal FIFO, counts drops on overflow, and drives AXI-Stream with programmable tlast packetisation.
- Sits between the core trace port and the DMA-facing AXI-Stream FIFO.

Parameters:
- XLEN, 64, pc width.
- NUM_RANGES, 4, number of address range comparators (1..8).
- FIFO_DEPTH, 16, internal buffer entries (power of 2, >=2).
- CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED, 1, 1 = ctrl write acts on rising edge of ctrl_write_enable; 0 = acts every cycle it is high.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- instr  in  32  executed instruction
- pc  in  XLEN  executed pc
- pc_valid  in  1  instr/pc executed this cycle
- M_AXIS_tvalid  out  1  FIFO not empty
- M_AXIS_tready  in  1  sink ready
- M_AXIS_tdata  out  XLEN+32  {pc, instr} at FIFO head
- M_AXIS_tlast  out  1  packet boundary flag at FIFO head
- ctrl_addr  in  8  control register address
- ctrl_wdata  in  64  control write data
- ctrl_write_enable  in  1  control write strobe
- trace_state  out  2  FSM state (ARMED=0, TRACING=1, ENDED=2, HALTED=3)
- dropped_count  out  32  admitted-but-dropped packets, saturating
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (async assert, sync release) state:
  - All enables 0; start_addr 0; end_addr all-ones.
  - Every range: lower 0, upper all-ones, disabled, mode include.
  - tlast_interval 0; state ARMED; FIFO empty; counters 0.
  - Outputs: tvalid 0, tlast 0, tdata 0, trace_state 0, dropped_count 0, fifo_level 0.
- Control map (write effective in the detected cycle):
  - 0 start_en[0]; 1 end_en[0]; 2 start_addr; 3 end_addr.
  - 4 any data: state -> ARMED, beat counter cleared.
  - 5 tlast_interval[31:0]; 6 retrigger_en[0]; 7 any data: dropped_count cleared.
  - 16+4i range i: +0 lower, +1 upper, +2 enable[0], +3 mode[0] (0 include, 1 exclude).
  - i >= NUM_RANGES and unmapped addresses ignored.
- Range rule, all bounds inclusive: in_range = (no enabled include range OR pc inside any enabled include range) AND pc inside no enabled exclude range.
- FSM (evaluated only when pc_valid):
  - ARMED: gate open if start_en==0, or if pc==start_addr (→TRACING, triggering instr captured).
  - TRACING: gate open; pc==end_addr with end_en → ENDED (end instr captured).
  - ENDED: gate closed; next cycle → ARMED if retrigger_en, else stay.
  - instr==WFI (0x0001) in ARMED-open or TRACING → instr captured with tlast forced, then → HALTED.
  - HALTED: gate closed until ctrl addr 4.
  - Priority: reset > ctrl addr 4 > WFI > end > start.
- Admit = pc_valid & gate_open & in_range.
- Latency: packet admitted in cycle N visible on tdata/tvalid at N+1.
- FIFO push succeeds if not full, or full with tvalid&tready in the same cycle (simultaneous push/pop). Otherwise the packet is dropped and dropped_count increments, saturating at 0xFFFFFFFF.
- Pop on tvalid&tready; tdata/tlast stable while tvalid&!tready.
- tlast stored per entry. Set on a successful push when beat_count == tlast_interval-1 (interval != 0) or on WFI; beat_count then resets to 0. Otherwise beat_count increments on each successful push.
- Dropped packets do not advance beat_count. A dropped WFI still moves the FSM to HALTED.
- Pointers wrap modulo FIFO_DEPTH. fifo_level ranges 0..FIFO_DEPTH.

Decomposition:
- Package cms_pkg holds:
  - Control address constants.
  - WFI_INSTRUCTION.
  - trace_state encoding enum.
  - Range register struct (lower, upper, enable, mode).
- Sub-module cms_stream_fifo: synchronous FIFO with AXI-Stream read side, level output and full/empty with simultaneous push/pop.
- The edge detector is reused for ctrl_write_enable.
- Range comparators are a generate loop in the top.

Test Plan:
- start_en=1, start_addr=0x100, end_en=1, end_addr=0x10C, pc sweep 0xF8..0x114 step 4, tready=1 -> exactly pcs 0x100..0x10C emitted; state ARMED→TRACING→ENDED, stays ENDED.
- Same with retrigger_en=1 and loop repeated twice -> two bursts of 4 beats; state returns to ARMED one cycle after ENDED.
- Range0 include [0x200,0x2FF], range1 exclude [0x240,0x24F], pcs 0x1FC..0x300 -> 0x240..0x24C absent, 0x200 and 0x2FC present, 0x1FC and 0x300 absent.
- tready=0, 20 admitted packets, FIFO_DEPTH=16 -> fifo_level=16, dropped_count=4; release tready -> 16 beats in order.
- tlast_interval=3, 7 packets then WFI -> tlast on beats 3, 6 and the WFI beat (8th); state HALTED, further pcs ignored until ctrl addr 4 write.
- Assert rst_n mid-stream with FIFO at level 5 -> tvalid, fifo_level, dropped_count drop to 0 immediately (asynchronously); all registers return to defaults.
